dds_tune_ctrl: RTL and testbench

- Downstream of the rotary/frequency-select stage in the DDS function generator.
- Consumes the 11-bit frequency index (Address) and its one-cycle change strobe (FreqChng).
- Computes the phase-increment tuning word with a multi-cycle shift-add multiplier and runs the phase accumulator.
- Applies each new tuning word only at a phase wrap, so the sine/waveform LUT address never jumps mid-period.

---
 rtl/dds_tune_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dds_tune_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_tune_ctrl.sv
// DDS tuning control: conditions the frequency index, computes the tuning word
// with a serial shift-add multiplier, and runs the phase accumulator. New
// tuning words are applied only at a phase wrap, so the LUT address stays
// continuous.
module dds_tune_ctrl #(
  parameter int unsigned IDX_W    = 11,
  parameter int unsigned IDX_MAX  = 1799,
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned PHASE_W  = 10,
  parameter int unsigned BASE_INC = 179,
  parameter int unsigned WAIT_MAX = 2400000
) (
  input  logic               Fg_CLK,
  input  logic               RESETn,
  input  logic [IDX_W-1:0]   Address,
  input  logic               FreqChng,
  input  logic               Enable,
  output logic [PHASE_W-1:0] Phase,
  output logic               PhaseWrap,
  output logic [ACC_W-1:0]   TuneWord,
  output logic               Busy,
  output logic               Loaded
);

  localparam int unsigned MUL_W = IDX_W + 1;
  localparam int unsigned CNT_W = (MUL_W > 1) ? $clog2(MUL_W) : 1;
  localparam int unsigned WC_W  = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic [1:0]       state_q, state_nxt;
  logic [MUL_W-1:0] m_q, m_nxt;
  logic [ACC_W-1:0] prod_q, prod_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [WC_W-1:0]  wait_q, wait_nxt;
  logic             pend_flag_q, pend_flag_nxt;
  logic [IDX_W-1:0] pend_idx_q, pend_idx_nxt;
  logic [ACC_W-1:0] tw_q, tw_nxt;
  logic             busy_q, busy_nxt;
  logic             loaded_q, loaded_nxt;
  logic [ACC_W-1:0] acc_q;
  logic             wrap_q;

  logic [IDX_W-1:0] idx_c;
  logic [MUL_W-1:0] m_in_c;
  logic [MUL_W-1:0] m_pend_c;
  logic [ACC_W:0]   sum_c;
  logic             carry_c;
  logic [ACC_W-1:0] add_c;

  // Index clamp, multiplier operands, partial product and accumulator sum
  always_comb begin
    idx_c    = (Address > IDX_W'(IDX_MAX)) ? IDX_W'(IDX_MAX) : Address;
    m_in_c   = MUL_W'(idx_c) + MUL_W'(1);
    m_pend_c = MUL_W'(pend_idx_q) + MUL_W'(1);
    sum_c    = {1'b0, acc_q} + {1'b0, tw_q};
    carry_c  = Enable & sum_c[ACC_W];
    add_c    = m_q[cnt_q] ? (ACC_W'(BASE_INC) << cnt_q) : '0;
  end

  // Next-state and control decode
  always_comb begin
    state_nxt     = state_q;
    m_nxt         = m_q;
    prod_nxt      = prod_q;
    cnt_nxt       = cnt_q;
    wait_nxt      = wait_q;
    pend_flag_nxt = pend_flag_q;
    pend_idx_nxt  = pend_idx_q;
    tw_nxt        = tw_q;
    loaded_nxt    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (FreqChng) begin
          m_nxt     = m_in_c;
          prod_nxt  = '0;
          cnt_nxt   = '0;
          state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        prod_nxt = prod_q + add_c;
        if (FreqChng) begin
          pend_idx_nxt  = idx_c;
          pend_flag_nxt = 1'b1;
        end
        if (cnt_q == CNT_W'(IDX_W)) begin
          wait_nxt  = '0;
          state_nxt = S_PEND;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      S_PEND: begin
        if (FreqChng) begin
          // abort: restart with the new index, no load
          m_nxt         = m_in_c;
          prod_nxt      = '0;
          cnt_nxt       = '0;
          pend_flag_nxt = 1'b0;
          state_nxt     = S_MUL;
        end else if (carry_c || !Enable || (wait_q == WC_W'(WAIT_MAX - 1))) begin
          tw_nxt     = prod_q;
          loaded_nxt = 1'b1;
          if (pend_flag_q) begin
            pend_flag_nxt = 1'b0;
            m_nxt         = m_pend_c;
            prod_nxt      = '0;
            cnt_nxt       = '0;
            state_nxt     = S_MUL;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          wait_nxt = wait_q + WC_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  // FSM and tuning-word registers
  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      state_q     <= S_IDLE;
      m_q         <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      pend_flag_q <= 1'b0;
      pend_idx_q  <= '0;
      tw_q        <= ACC_W'(BASE_INC);
      busy_q      <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      m_q         <= m_nxt;
      prod_q      <= prod_nxt;
      cnt_q       <= cnt_nxt;
      wait_q      <= wait_nxt;
      pend_flag_q <= pend_flag_nxt;
      pend_idx_q  <= pend_idx_nxt;
      tw_q        <= tw_nxt;
      busy_q      <= busy_nxt;
      loaded_q    <= loaded_nxt;
    end
  end

  // Phase accumulator and registered wrap pulse
  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      acc_q  <= '0;
      wrap_q <= 1'b0;
    end else if (Enable) begin
      acc_q  <= sum_c[ACC_W-1:0];
      wrap_q <= sum_c[ACC_W];
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign Phase     = acc_q[ACC_W-1 -: PHASE_W];
  assign PhaseWrap = wrap_q;
  assign TuneWord  = tw_q;
  assign Busy      = busy_q;
  assign Loaded    = loaded_q;

endmodule

// File: tb/tb_dds_tune_ctrl.sv
// Directed bench for dds_tune_ctrl with a 16-bit accumulator, BASE_INC=3 and
// WAIT_MAX=64; Phase is made full width so it equals the accumulator.
module tb_dds_tune_ctrl;

  localparam int unsigned IDX_W   = 11;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned PHASE_W = 16;

  logic               Fg_CLK = 1'b0;
  logic               RESETn;
  logic [IDX_W-1:0]   Address;
  logic               FreqChng;
  logic               Enable;
  logic [PHASE_W-1:0] Phase;
  logic               PhaseWrap;
  logic [ACC_W-1:0]   TuneWord;
  logic               Busy;
  logic               Loaded;

  int vecs = 0;
  int errs = 0;
  int nload;

  dds_tune_ctrl #(
    .IDX_W(IDX_W), .IDX_MAX(1799), .ACC_W(ACC_W), .PHASE_W(PHASE_W),
    .BASE_INC(3), .WAIT_MAX(64)
  ) dut (
    .Fg_CLK(Fg_CLK), .RESETn(RESETn), .Address(Address), .FreqChng(FreqChng),
    .Enable(Enable), .Phase(Phase), .PhaseWrap(PhaseWrap), .TuneWord(TuneWord),
    .Busy(Busy), .Loaded(Loaded)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  task automatic step();
    @(posedge Fg_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // advance n cycles, counting Loaded pulses seen
  task automatic steps(input int n, output int nl);
    nl = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (Loaded === 1'b1) nl++;
    end
  endtask

  // one-cycle strobe; returns at the first cycle after the strobe
  task automatic strobe(input logic [IDX_W-1:0] a);
    Address  = a;
    FreqChng = 1'b1;
    step();
    FreqChng = 1'b0;
  endtask

  task automatic wait_load(input int n);
    for (int i = 0; i < n && Loaded !== 1'b1; i++) step();
    chk("load_seen", 32'(Loaded), 1);
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    step();
    RESETn = 1'b1;
  endtask

  initial begin
    RESETn = 1'b0; Enable = 1'b0; FreqChng = 1'b0; Address = '0;
    step();
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_tw", 32'(TuneWord), 3);
    step();
    RESETn = 1'b1;
    step();
    chk("idle_tw", 32'(TuneWord), 3);
    chk("idle_phase", 32'(Phase), 0);
    chk("idle_busy", 32'(Busy), 0);
    chk("idle_loaded", 32'(Loaded), 0);
    chk("idle_wrap", 32'(PhaseWrap), 0);

    // latency with Enable=0, Address=9
    strobe(11'd9);
    chk("lat_busy_c1", 32'(Busy), 1);
    steps(12, nload);
    chk("lat_busy_c13", 32'(Busy), 1);
    chk("lat_noload_c1_13", 32'(nload), 0);
    chk("lat_tw_c13", 32'(TuneWord), 3);
    step();
    chk("lat_loaded_c14", 32'(Loaded), 1);
    chk("lat_tw_c14", 32'(TuneWord), 30);
    chk("lat_busy_c14", 32'(Busy), 0);
    step();
    chk("lat_loaded_c15", 32'(Loaded), 0);
    chk("lat_busy_c15", 32'(Busy), 0);

    // clamp and index zero
    strobe(11'd2047);
    wait_load(40);
    chk("clamp_tw", 32'(TuneWord), 5400);
    step();
    strobe(11'd0);
    wait_load(40);
    chk("idx0_tw", 32'(TuneWord), 3);
    step();

    // Enable=1, no wrap possible: forced load after 64 PEND cycles
    Enable = 1'b1;
    strobe(11'd9);
    chk("to_phase_c1", 32'(Phase), 3);
    steps(75, nload);
    chk("to_noload", 32'(nload), 0);
    chk("to_phase_c76", 32'(Phase), 228);
    chk("to_tw_c76", 32'(TuneWord), 3);
    step();
    chk("to_loaded_c77", 32'(Loaded), 1);
    chk("to_tw_c77", 32'(TuneWord), 30);
    chk("to_phase_c77", 32'(Phase), 231);
    step();
    chk("to_phase_c78", 32'(Phase), 261);
    chk("to_loaded_c78", 32'(Loaded), 0);
    Enable = 1'b0;

    // load at a wrap with TuneWord=5400
    do_reset();
    strobe(11'd1799);
    wait_load(40);
    chk("wr_tw0", 32'(TuneWord), 5400);
    Enable = 1'b1;
    strobe(11'd9);
    chk("wr_phase_c1", 32'(Phase), 5400);
    steps(11, nload);
    chk("wr_phase_c12", 32'(Phase), 64800);
    step();
    chk("wr_phase_c13", 32'(Phase), 4664);
    chk("wr_wrap_c13", 32'(PhaseWrap), 1);
    steps(11, nload);
    chk("wr_noload", 32'(nload), 0);
    chk("wr_phase_c24", 32'(Phase), 64064);
    step();
    chk("wr_loaded_c25", 32'(Loaded), 1);
    chk("wr_tw_c25", 32'(TuneWord), 30);
    chk("wr_phase_c25", 32'(Phase), 3928);
    chk("wr_wrap_c25", 32'(PhaseWrap), 1);
    step();
    chk("wr_phase_c26", 32'(Phase), 3958);
    chk("wr_wrap_c26", 32'(PhaseWrap), 0);
    chk("wr_busy_c26", 32'(Busy), 0);
    Enable = 1'b0;

    // second strobe during MUL: two loads, 30 then 15
    do_reset();
    strobe(11'd9);
    steps(2, nload);
    strobe(11'd4);
    steps(10, nload);
    chk("dbl_loaded1", 32'(Loaded), 1);
    chk("dbl_tw1", 32'(TuneWord), 30);
    chk("dbl_busy1", 32'(Busy), 1);
    steps(12, nload);
    chk("dbl_noload", 32'(nload), 0);
    step();
    chk("dbl_loaded2", 32'(Loaded), 1);
    chk("dbl_tw2", 32'(TuneWord), 15);
    step();
    chk("dbl_busy_end", 32'(Busy), 0);

    // strobe during PEND aborts the load
    strobe(11'd9);
    steps(12, nload);
    chk("ab_busy_pend", 32'(Busy), 1);
    strobe(11'd19);
    chk("ab_loaded_c14", 32'(Loaded), 0);
    chk("ab_tw_c14", 32'(TuneWord), 15);
    chk("ab_busy_c14", 32'(Busy), 1);
    steps(12, nload);
    chk("ab_noload", 32'(nload), 0);
    step();
    chk("ab_loaded", 32'(Loaded), 1);
    chk("ab_tw", 32'(TuneWord), 60);
    step();

    // reset mid-MUL
    strobe(11'd9);
    steps(4, nload);
    RESETn = 1'b0;
    step();
    chk("rm_busy", 32'(Busy), 0);
    chk("rm_tw", 32'(TuneWord), 3);
    chk("rm_loaded", 32'(Loaded), 0);
    RESETn = 1'b1;
    steps(20, nload);
    chk("rm_noload", 32'(nload), 0);
    chk("rm_busy_after", 32'(Busy), 0);

    // reset mid-PEND with the accumulator running
    Enable = 1'b1;
    strobe(11'd9);
    steps(29, nload);
    chk("rp_busy_c30", 32'(Busy), 1);
    chk("rp_phase_c30", 32'(Phase), 90);
    RESETn = 1'b0;
    step();
    chk("rp_phase", 32'(Phase), 0);
    chk("rp_tw", 32'(TuneWord), 3);
    chk("rp_busy", 32'(Busy), 0);
    chk("rp_loaded", 32'(Loaded), 0);
    RESETn = 1'b1;
    Enable = 1'b0;
    steps(80, nload);
    chk("rp_noload", 32'(nload), 0);
    chk("rp_phase_hold", 32'(Phase), 0);
    chk("rp_tw_hold", 32'(TuneWord), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
